// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage. Owns the fetch PC, issues word reads to instruction
//            memory over req/ack, queues returned words with their PC for
//            decode, flushes on execute redirects, and halts with a sticky
//            fault when the fetch address leaves instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] ADDR_LIMIT = 32'd32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        fetch_fault
);

    localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_REQ   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_HALT  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [31:0]        r_fetch_pc;
    logic               r_req;
    logic [31:0]        r_addr;
    logic               r_fault;

    logic [31:0]        r_q_pc    [DEPTH];
    logic [31:0]        r_q_instr [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_ack;
    logic               w_pop;
    logic               w_push;
    logic [31:0]        w_pc_inc;
    logic               w_cur_legal;
    logic               w_inc_legal;
    logic [c_CNT_W-1:0] w_count_after;

    logic               w_req_nxt;
    logic [31:0]        w_addr_nxt;
    logic [31:0]        w_fetch_pc_nxt;
    logic               w_fault_nxt;

    // An ack only means something while a request is on the bus
    assign w_ack       = r_req & imem_ack;
    assign w_pop       = if_valid & if_ready;
    // Data returned in a redirect cycle belongs to the squashed path
    assign w_push      = (r_state == c_S_REQ) & w_ack & ~redirect_valid;
    assign w_pc_inc    = r_fetch_pc + 32'd4;
    assign w_cur_legal = (r_fetch_pc < ADDR_LIMIT);
    assign w_inc_legal = (w_pc_inc < ADDR_LIMIT);
    assign w_count_after = r_count + (w_push ? c_CNT_ONE : '0) - (w_pop ? c_CNT_ONE : '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a redirect overrides every state
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (r_req && !imem_ack) ? c_S_DRAIN : c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (!w_cur_legal)           w_state_nxt = c_S_HALT;
                    else if (r_count < c_DEPTH) w_state_nxt = c_S_REQ;
                end
                c_S_REQ: begin
                    if (w_ack) begin
                        if (!w_inc_legal)                 w_state_nxt = c_S_HALT;
                        else if (w_count_after < c_DEPTH) w_state_nxt = c_S_REQ;
                        else                              w_state_nxt = c_S_IDLE;
                    end
                end
                c_S_DRAIN: begin
                    if (w_ack) w_state_nxt = c_S_IDLE;
                end
                default: w_state_nxt = c_S_HALT;
            endcase
        end
    end

    // Output logic: next values of the registered bus, fetch PC and fault
    always_comb begin
        w_req_nxt      = r_req;
        w_addr_nxt     = r_addr;
        w_fetch_pc_nxt = r_fetch_pc;
        w_fault_nxt    = r_fault;
        if (redirect_valid) begin
            w_fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
            w_fault_nxt    = 1'b0;
            // Memory cannot cancel: keep req up until the pending ack lands
            w_req_nxt      = r_req & ~imem_ack;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (!w_cur_legal) begin
                        w_fault_nxt = 1'b1;
                        w_req_nxt   = 1'b0;
                    end else if (r_count < c_DEPTH) begin
                        w_req_nxt  = 1'b1;
                        w_addr_nxt = r_fetch_pc;
                    end
                end
                c_S_REQ: begin
                    if (w_ack) begin
                        w_fetch_pc_nxt = w_pc_inc;
                        if (!w_inc_legal) begin
                            w_fault_nxt = 1'b1;
                            w_req_nxt   = 1'b0;
                        end else if (w_count_after < c_DEPTH) begin
                            w_req_nxt  = 1'b1;
                            w_addr_nxt = w_pc_inc;
                        end else begin
                            w_req_nxt = 1'b0;
                        end
                    end
                end
                c_S_DRAIN: begin
                    if (w_ack) w_req_nxt = 1'b0;
                end
                default: w_req_nxt = 1'b0;
            endcase
        end
    end

    // Fetch PC, memory bus and fault registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fault    <= 1'b0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
            r_count <= w_count_after;
        end
    end

    // Queue storage; contents are qualified by the count, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wptr]    <= r_fetch_pc;
            r_q_instr[r_wptr] <= imem_rdata;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign fetch_fault = r_fault;
    assign if_valid    = (r_count != '0) & ~redirect_valid;
    assign if_instr    = if_valid ? r_q_instr[r_rptr]       : 32'd0;
    assign if_pc       = if_valid ? r_q_pc[r_rptr]          : 32'd0;
    assign if_pc4      = if_valid ? r_q_pc[r_rptr] + 32'd4  : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit with a
//            configurable-latency instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;
    int lat      = 0;
    int wait_cnt = 0;

    logic [31:0] acc_addr [$];
    logic [31:0] got_pc   [$];
    logic [31:0] got_pc4  [$];
    logic [31:0] got_ins  [$];

    localparam logic [31:0] c_TAG = 32'hDEAD_0000;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory model: ack after lat cycles (lat=0 means same cycle as req)
    assign imem_ack   = imem_req && ((lat == 0) || (wait_cnt == lat - 1));
    assign imem_rdata = imem_addr ^ c_TAG;

    always @(posedge clk or posedge rst) begin
        if (rst)                        wait_cnt <= 0;
        else if (imem_req && imem_ack)  wait_cnt <= 0;
        else if (imem_req)              wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    // Monitor: inputs only change just after posedge, so negedge values hold to the edge
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_ack) acc_addr.push_back(imem_addr);
            if (if_valid && if_ready) begin
                got_pc.push_back(if_pc);
                got_pc4.push_back(if_pc4);
                got_ins.push_back(if_instr);
            end
        end
    end

    task automatic clear_logs();
        acc_addr.delete();
        got_pc.delete();
        got_pc4.delete();
        got_ins.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic wait_req_addr(input logic [31:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == a) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        @(posedge clk);
        #1;
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: req=%b valid=%b fault=%b, required 0 0 0", imem_req, if_valid, fetch_fault);
        end
        checks++;
        if (imem_addr !== 32'd0 || if_pc !== 32'd0 || if_instr !== 32'd0 || if_pc4 !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: addr=%h pc=%h instr=%h pc4=%h, required all 0", imem_addr, if_pc, if_instr, if_pc4);
        end
    endtask

    task automatic test_zero_wait();
        lat = 0;
        if_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                failures++;
                $display("FAIL zw_addr[%0d]: req=%b addr=%h, required 1 %h", k, imem_req, imem_addr, 32'(4 * k));
            end
            if (k > 0) begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 1)) || if_pc4 !== 32'(4 * k) ||
                    if_instr !== (32'(4 * (k - 1)) ^ c_TAG)) begin
                    failures++;
                    $display("FAIL zw_head[%0d]: valid=%b pc=%h pc4=%h instr=%h, required 1 %h %h %h",
                             k, if_valid, if_pc, if_pc4, if_instr, 32'(4 * (k - 1)), 32'(4 * k),
                             32'(4 * (k - 1)) ^ c_TAG);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        lat = 0;
        if_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        checks++;
        if (acc_addr.size() != 4 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL bp_credit: requests=%0d req=%b, required 4 0", acc_addr.size(), imem_req);
        end
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            failures++;
            $display("FAIL bp_head: valid=%b pc=%h, required 1 00000000", if_valid, if_pc);
        end
        @(posedge clk);
        #1;
        if_ready = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (acc_addr.size() < 5 || got_pc.size() < 5) begin
            failures++;
            $display("FAIL bp_resume_count: requests=%0d delivered=%0d, required >=5 >=5", acc_addr.size(), got_pc.size());
        end else begin
            checks++;
            if (acc_addr[4] !== 32'h10) begin
                failures++;
                $display("FAIL bp_resume_addr: addr=%h, required 00000010", acc_addr[4]);
            end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_pc[i] !== 32'(4 * i) || got_ins[i] !== (32'(4 * i) ^ c_TAG)) begin
                    failures++;
                    $display("FAIL bp_order[%0d]: pc=%h instr=%h, required %h %h", i, got_pc[i], got_ins[i],
                             32'(4 * i), 32'(4 * i) ^ c_TAG);
                end
            end
        end
    endtask

    task automatic test_redirect_drain();
        bit ok;
        lat = 3;
        if_ready = 1'b1;
        do_reset();
        wait_req_addr(32'h8, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drain_setup: no request for 00000008 seen, required one");
            return;
        end
        pulse_redirect(32'h102);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_hold: req=%b addr=%h valid=%b, required 1 00000008 0", imem_req, imem_addr, if_valid);
        end
        wait_req_addr(32'h100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drain_next_addr: addr=%h, required 00000100", imem_addr);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (got_pc.size() == 0 || got_pc[0] !== 32'h100 || got_pc4[0] !== 32'h104 ||
            got_ins[0] !== (32'h100 ^ c_TAG)) begin
            failures++;
            $display("FAIL drain_first_pc: count=%0d pc=%h, required >0 00000100",
                     got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_redirect_with_ack();
        bit ok;
        bit seen8;
        lat = 2;
        if_ready = 1'b1;
        do_reset();
        wait_req_addr(32'h8, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ack_redir_setup: no request for 00000008 seen, required one");
            return;
        end
        // Redirect lands in the cycle where the ack for 0x8 is presented
        pulse_redirect(32'h200);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL ack_redir_nodrain: req=%b, required 0", imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL ack_redir_addr: req=%b addr=%h, required 1 00000200", imem_req, imem_addr);
        end
        repeat (10) @(negedge clk);
        seen8 = 1'b0;
        foreach (got_pc[i]) if (got_pc[i] == 32'h8) seen8 = 1'b1;
        checks++;
        if (seen8 || got_pc.size() == 0 || got_pc[0] !== 32'h200) begin
            failures++;
            $display("FAIL ack_redir_stream: saw8=%b count=%0d first=%h, required 0 >0 00000200",
                     seen8, got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_fault();
        lat = 0;
        if_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        pulse_redirect(32'h7FFC);
        repeat (6) @(negedge clk);
        checks++;
        if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL fault_set: fault=%b req=%b, required 1 0", fetch_fault, imem_req);
        end
        checks++;
        if (got_pc.size() != 1 || got_pc[0] !== 32'h7FFC || got_ins[0] !== (32'h7FFC ^ c_TAG)) begin
            failures++;
            $display("FAIL fault_last: count=%0d pc=%h, required 1 00007ffc",
                     got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hFFFF_FFFF);
        end
        pulse_redirect(32'h40);
        @(negedge clk);
        checks++;
        if (fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL fault_clear: fault=%b, required 0", fetch_fault);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (got_pc.size() == 0 || got_pc[0] !== 32'h40) begin
            failures++;
            $display("FAIL fault_resume: count=%0d first=%h, required >0 00000040",
                     got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        lat = 3;
        if_ready = 1'b0;
        do_reset();
        wait_req_addr(32'h8, ok);
        checks++;
        if (!ok || acc_addr.size() != 2 || if_valid !== 1'b1) begin
            failures++;
            $display("FAIL arst_setup: found=%b acks=%0d valid=%b, required 1 2 1", ok, acc_addr.size(), if_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL arst_immediate: req=%b valid=%b fault=%b, required 0 0 0", imem_req, if_valid, fetch_fault);
        end
        @(posedge clk);
        #1;
        clear_logs();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL arst_restart: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_drain();
        test_redirect_with_ack();
        test_fault();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage between the program counter and decode. Owns the fetch PC, issues word reads to instruction memory over a request/acknowledge handshake, and buffers returned instructions with their PC and PC+4 in a small queue. Decode consumes the queue through a valid/ready handshake. Branch/jump redirects from execute flush the queue. Fetch halts with a sticky fault, not a simulation stop, when the address leaves instruction memory.

## Interface
- DEPTH, 4: instruction queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000: fetch address after reset
- ADDR_LIMIT, 32768: first illegal byte address (4*8192)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  execute-stage branch/jump taken
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0
- imem_req  out  1  read request, registered
- imem_addr  out  32  word-aligned read address, registered
- imem_ack  in  1  read complete; sampled only while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- if_valid  out  1  queue head valid for decode
- if_ready  in  1  decode accepts head
- if_instr  out  32  head instruction
- if_pc  out  32  head address
- if_pc4  out  32  head address + 4
- fetch_fault  out  1  sticky: fetch address ≥ ADDR_LIMIT

## Operation
- Registers: fetch_pc, state {IDLE, REQ, DRAIN, HALT}, queue (pc, instr) of DEPTH entries, count.
- Reset values: state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, count=0, fetch_fault=0. if_instr/if_pc/if_pc4 read 0 whenever if_valid=0.
- IDLE: fetch_pc ≥ ADDR_LIMIT → HALT, fetch_fault=1. Else if count < DEPTH → REQ, imem_req=1, imem_addr=fetch_pc.
- REQ: imem_req and imem_addr stay stable until imem_ack. On ack, push {fetch_pc, imem_rdata} and set fetch_pc += 4 (32-bit wrap). The next step uses the new fetch_pc: legal and count_after < DEPTH → stay REQ with the new address (back-to-back). Illegal → HALT. Else → IDLE with imem_req=0.
- Credit rule: a request issues only when a queue slot is free at issue time. Push never overflows.
- Pop: if_valid && if_ready removes the head. Push and pop in the same cycle leave count unchanged.
- if_valid = (count≠0) && !redirect_valid. Decode never completes a transfer in a redirect cycle.
- Redirect (any state): flush queue (count=0), fetch_pc=redirect_pc & ~3, fetch_fault=0.
  - Request outstanding without ack this cycle → DRAIN. imem_req stays high, and the returned data is discarded on ack.
  - Otherwise (including ack in the same cycle) → IDLE. The ack data is discarded.
- DRAIN: on ack → IDLE, no push. A further redirect in DRAIN only updates fetch_pc.
- HALT: no requests. Queue continues to drain to decode. Leaves only on redirect or rst.
- Memory cannot cancel a request. The block never drops imem_req before imem_ack.

## Timing
- First posedge after rst release: imem_req=1, imem_addr=RESET_PC.
- Zero-wait memory (ack in the same cycle as req): one fetch per cycle. An instruction acked at edge N shows if_valid at edge N (visible in cycle N+1).
- Redirect to first new request: 1 cycle with no outstanding request; otherwise the remaining memory latency + 1.
- rst asserted at any time clears imem_req, if_valid and fetch_fault immediately, without waiting for clk.

## Test plan
- Reset release, imem_ack=imem_req (zero-wait), if_ready=1 → imem_addr 0,4,8,12 on consecutive cycles; if_pc 0,4,8 with if_pc4 4,8,12; one instruction per cycle.
- if_ready=0, zero-wait memory → exactly 4 requests (0x0–0xC), then imem_req=0. Raise if_ready → next request at 0x10 and if_pc order 0,4,8,C,10.
- 3-cycle ack latency, redirect_pc=0x102 while the request for 0x8 is pending → imem_req held at 0x8 until ack, data discarded, next imem_addr=0x100, first if_pc=0x100.
- redirect_valid in the same cycle as imem_ack for 0x8, redirect_pc=0x200 → no DRAIN, next imem_addr=0x200, 0x8 never appears at decode.
- redirect_pc=0x7FFC → 0x7FFC delivered, then fetch_fault=1 and imem_req=0. Later redirect_pc=0x40 → fetch_fault=0 and fetch resumes at 0x40.
- rst asserted mid-cycle with a request outstanding and queue count 2 → imem_req=0 and if_valid=0 before the next clk edge. After release, the fetch restarts at RESET_PC.
